// File: rtl/sdm_mc_tx_pkg.sv
// Shared types and helpers for the multi-channel sigma-delta transmitter.
package sdm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } st_t;

  localparam logic ORD1 = 1'b0;
  localparam logic ORD2 = 1'b1;

  // Feedback value for a DW-bit signed full scale: +FS when the last bit was 1, else -FS.
  function automatic int fb(logic b, int unsigned dw);
    int fs;
    fs = 1 << (dw - 1);
    return b ? fs : -fs;
  endfunction

  // Clamp v to the range of a w-bit signed register.
  function automatic int sat(int v, int unsigned w);
    int hi;
    int lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/sdm_mc_tx_if.sv
// Frame write port and FIFO status of the multi-channel sigma-delta transmitter.
interface sdm_mc_tx_if #(
  parameter int CH = 2,
  parameter int DW = 4,
  parameter int AW = 2
);
  logic              push;
  logic              clear;
  logic [CH*DW-1:0]  wdata;
  logic              full;
  logic              empty;
  logic [AW:0]       level;
  logic              overflow;

  modport master (
    output push, clear, wdata,
    input  full, empty, level, overflow
  );

  modport slave (
    input  push, clear, wdata,
    output full, empty, level, overflow
  );
endinterface

// File: rtl/sdm_mc_tx_chan.sv
// One sigma-delta modulator channel: 1st/2nd-order loop with saturating integrators.
module sdm_mc_chan
  import sdm_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic signed [DW-1:0] x,
  input  logic                 tick,
  input  logic                 ord,
  input  logic                 clr,
  output logic                 tx
);
  localparam int unsigned W1 = DW + 2;
  localparam int unsigned W2 = DW + 4;

  logic signed [W1-1:0] i1, i1_nx;
  logic signed [W2-1:0] i2, i2_nx;
  logic                 tx_nx;
  int                   f, s1, s2;

  // The second integrator sees the already-updated first integrator.
  always_comb begin
    f  = fb(tx, DW);
    s1 = sat(int'(i1) + int'(x) - f, W1);
    s2 = sat(int'(i2) + s1 - f, W2);
    i1_nx = s1[W1-1:0];
    if (ord == ORD2) begin
      i2_nx = s2[W2-1:0];
      tx_nx = (s2 >= 0);
    end else begin
      i2_nx = '0;
      tx_nx = (s1 >= 0);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      i1 <= '0;
      i2 <= '0;
      tx <= 1'b0;
    end else if (clr) begin
      i1 <= '0;
      i2 <= '0;
      tx <= 1'b0;
    end else if (tick) begin
      i1 <= i1_nx;
      i2 <= i2_nx;
      tx <= tx_nx;
    end
  end
endmodule

// File: rtl/sdm_mc_tx.sv
// Multi-channel sigma-delta transmitter: frame FIFO, fclk tick recovery, frame sequencer.
module sdm_mc_tx
  import sdm_pkg::*;
#(
  parameter int CH  = 2,
  parameter int DW  = 4,
  parameter int AW  = 2,
  parameter int OSR = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          setn,
  input  logic          fclk,
  input  logic          ord,
  sdm_mc_tx_if.slave    bus,
  output logic          underrun,
  output logic [1:0]    st,
  output logic [CH-1:0] tx
);
  localparam int DEPTH = 1 << AW;
  localparam int CW    = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(OSR - 1);

  logic             push_d;
  logic [2:0]       f_sync;
  logic             tick, tick_run, clr_mod;
  logic [CH*DW-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic [AW:0]      lvl;
  logic             full, empty, ovf_q;
  logic             wr_req, wr_en, pop, load, set_ur;
  st_t              st_q, st_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             ord_q;
  logic [CH*DW-1:0] samp;

  assign full         = (lvl == (AW+1)'(DEPTH));
  assign empty        = (lvl == '0);
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.level    = lvl;
  assign bus.overflow = ovf_q;
  assign st           = st_q;

  assign wr_req = bus.push ^ push_d;
  assign wr_en  = wr_req & ~full & ~bus.clear;

  // fclk is asynchronous: two-stage synchroniser, third stage for the rising-edge detect.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) f_sync <= '0;
    else       f_sync <= {f_sync[1:0], fclk};
  end
  assign tick = f_sync[1] & ~f_sync[2];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wp] <= bus.wdata;
  end

  // push_d tracks push during reset so the release edge never looks like a toggle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      push_d   <= bus.push;
      wp       <= '0;
      rp       <= '0;
      lvl      <= '0;
      ovf_q    <= 1'b0;
      underrun <= 1'b0;
    end else begin
      push_d <= bus.push;
      if (bus.clear) begin
        wp       <= '0;
        rp       <= '0;
        lvl      <= '0;
        ovf_q    <= 1'b0;
        underrun <= 1'b0;
      end else begin
        if (wr_en) wp <= wp + AW'(1);
        if (pop)   rp <= rp + AW'(1);
        if (wr_en && !pop)      lvl <= lvl + (AW+1)'(1);
        else if (!wr_en && pop) lvl <= lvl - (AW+1)'(1);
        if (wr_req && full) ovf_q    <= 1'b1;
        if (set_ur)         underrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q  <= IDLE;
      cnt   <= '0;
      ord_q <= ORD1;
      samp  <= '0;
    end else begin
      st_q <= st_nx;
      cnt  <= cnt_nx;
      if (st_q == IDLE) ord_q <= ord;
      if (load)         samp  <= mem[rp];
    end
  end

  always_comb begin
    st_nx  = st_q;
    cnt_nx = cnt;
    pop    = 1'b0;
    load   = 1'b0;
    set_ur = 1'b0;
    unique case (st_q)
      IDLE: if (setn && !empty) st_nx = LOAD;
      LOAD: begin
        pop    = !empty;
        load   = 1'b1;
        cnt_nx = CNT_MAX;
        st_nx  = RUN;
      end
      RUN: if (tick) begin
        if (cnt == '0) begin
          cnt_nx = CNT_MAX;
          if (!empty) begin
            pop  = 1'b1;
            load = 1'b1;
          end else begin
            set_ur = 1'b1;
          end
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      default: st_nx = IDLE;
    endcase
    // Dropping setn abandons the run without consuming any queued frame.
    if (!setn) begin
      st_nx  = IDLE;
      pop    = 1'b0;
      load   = 1'b0;
      set_ur = 1'b0;
    end
  end

  assign clr_mod  = !setn || (st_q == IDLE);
  assign tick_run = tick && (st_q == RUN);

  for (genvar k = 0; k < CH; k++) begin : g_ch
    sdm_mc_chan #(.DW(DW)) u_chan (
      .clk  (clk),
      .rstn (rstn),
      .x    (samp[k*DW +: DW]),
      .tick (tick_run),
      .ord  (ord_q),
      .clr  (clr_mod),
      .tx   (tx[k])
    );
  end
endmodule
